seq_pattern_tx: RTL

- Serial pattern transmitter. Accepts a parallel pattern word over a valid/ready handshake and shifts it out one bit per clock on a single serial line.
- Frames are separated by a programmable idle gap.
- It is the driving end for the serial sequence detectors (e.g. the 1001 detector): its `out` feeds a detector's `in` directly, on the same clock.

---
 rtl/seq_tx_pkg.sv | 23 ++
 rtl/piso_shift_reg.sv | 36 +++
 rtl/seq_pattern_tx.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// Holds the FSM state encoding, the counter-width helper and the canonical 1001 pattern.
package seq_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } tx_state_t;

    localparam logic [3:0] PAT_1001 = 4'b1001;

    // Bits needed to hold 0..maxCount, i.e. clog2(maxCount+1), never less than one.
    function automatic int cntWidth(input int maxCount);
        int w;
        w = 1;
        while ((1 << w) < (maxCount + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, serial-out shift register; LSB_FIRST selects which end is presented on q.
// Zeros are shifted in, so the register drains to all-zero once a frame has been sent.
module piso_shift_reg
    import seq_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             shift,
    output logic             q
);

    logic [WIDTH-1:0] r_data;

    // Load wins over shift so a back-to-back word replaces the drained register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= d;
        end else if (shift) begin
            if (LSB_FIRST) begin
                r_data <= r_data >> 1;
            end else begin
                r_data <= r_data << 1;
            end
        end
    end

    assign q = LSB_FIRST ? r_data[0] : r_data[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: valid/ready word intake, one bit per clock out, programmable idle gap.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit to every frame.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int GAP       = 1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int BW = cntWidth(WIDTH);
    localparam int GW = cntWidth(GAP);
    localparam bit HAS_GAP = (GAP > 0);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'((GAP > 0) ? (GAP - 1) : 0);

    tx_state_t r_state;
    tx_state_t w_nextState;
    logic [BW-1:0] r_bitCnt;
    logic [BW-1:0] w_nextBitCnt;
    logic [GW-1:0] r_gapCnt;
    logic [GW-1:0] w_nextGapCnt;
    logic r_outValid;
    logic w_load;
    logic w_shift;
    logic w_flush;
    logic w_lastBit;
    logic w_lastGap;
    logic w_inReady;
    logic w_accept;
    logic w_pisoQ;
    logic [FRAME_BITS-1:0] w_frame;
    logic [FRAME_BITS-1:0] w_pisoD;

`ifdef SEQ_PATTERN_TX_PARITY_EN
    // Parity sits at whichever end leaves the register last.
    assign w_frame = LSB_FIRST ? {^in_data, in_data} : {in_data, ^in_data};
`else
    assign w_frame = in_data;
`endif

    assign w_pisoD   = w_flush ? '0 : w_frame;
    assign w_lastBit = (r_bitCnt == LAST_BIT);
    assign w_lastGap = (r_gapCnt == LAST_GAP);

    // Ready in IDLE, and in the final cycle of a frame (GAP==0) or of the gap (GAP>0).
    always_comb begin
        w_inReady = 1'b0;
        if (rst) begin
            case (r_state)
                ST_IDLE:  w_inReady = 1'b1;
                ST_SHIFT: w_inReady = !HAS_GAP && w_lastBit;
                ST_GAP:   w_inReady = HAS_GAP && w_lastGap;
                default:  w_inReady = 1'b0;
            endcase
        end
    end

    assign w_accept = in_valid & w_inReady;

    always_comb begin
        w_nextState  = r_state;
        w_nextBitCnt = r_bitCnt;
        w_nextGapCnt = r_gapCnt;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextState  = ST_SHIFT;
                    w_nextBitCnt = '0;
                    w_load       = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!w_lastBit) begin
                    w_shift      = 1'b1;
                    w_nextBitCnt = r_bitCnt + 1'b1;
                end else if (w_accept) begin
                    w_load       = 1'b1;
                    w_nextBitCnt = '0;
                end else if (HAS_GAP) begin
                    w_shift      = 1'b1;
                    w_nextState  = ST_GAP;
                    w_nextGapCnt = '0;
                end else begin
                    w_shift      = 1'b1;
                    w_nextState  = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (!w_lastGap) begin
                    w_nextGapCnt = r_gapCnt + 1'b1;
                end else if (w_accept) begin
                    w_nextState  = ST_SHIFT;
                    w_nextBitCnt = '0;
                    w_load       = 1'b1;
                end else begin
                    w_nextState  = ST_IDLE;
                end
            end
            default: begin
                // Unreachable encoding: recover to IDLE with a clean serial line.
                w_nextState  = ST_IDLE;
                w_nextBitCnt = '0;
                w_nextGapCnt = '0;
                w_load       = 1'b1;
                w_flush      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_bitCnt   <= '0;
            r_gapCnt   <= '0;
            r_outValid <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_bitCnt   <= w_nextBitCnt;
            r_gapCnt   <= w_nextGapCnt;
            r_outValid <= (w_nextState == ST_SHIFT);
        end
    end

    piso_shift_reg #(
        .WIDTH     (FRAME_BITS),
        .LSB_FIRST (LSB_FIRST)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .d     (w_pisoD),
        .shift (w_shift),
        .q     (w_pisoQ)
    );

    assign in_ready  = w_inReady;
    assign out       = w_pisoQ;
    assign out_valid = r_outValid;
    assign busy      = (r_state == ST_SHIFT) || (r_state == ST_GAP);
    assign done      = (r_state == ST_SHIFT) && w_lastBit;

endmodule
